// File: rtl/cache_ctrl_2way.sv
// cache_ctrl_2way
//   Control FSM for a 2-way set-associative, write-back, write-allocate cache
//   with multi-word lines. Hits complete in the request cycle. On a miss, the
//   controller picks a victim using per-set LRU bits, bursts a dirty victim
//   back to memory, bursts the new line in through a pipelined read port,
//   then replays the original access.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rd, wr, index            core request (held stable while stall=1)
//   hit0/1, valid0/1,
//   dirty0/1                 per-way tag compare result and line status
//   mem_stall, mem_rvalid    memory handshake (accept / read data present)
//   mem_err, cache_err       error indications
//   comp, way, cache_en,
//   cache_write, fill,
//   word_off                 way-array control
//   wb_tag_sel, mem_rd,
//   mem_wr                   memory control
//   stall, done, cache_hit,
//   err                      core handshake and completion status
module cache_ctrl_2way #(
  parameter int OFF_W   = 2,
  parameter int IDX_W   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd,
  input  logic             wr,
  input  logic [IDX_W-1:0] index,
  input  logic             hit0,
  input  logic             hit1,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             dirty0,
  input  logic             dirty1,
  input  logic             mem_stall,
  input  logic             mem_rvalid,
  input  logic             mem_err,
  input  logic             cache_err,
  output logic             comp,
  output logic             way,
  output logic             cache_en,
  output logic             cache_write,
  output logic             fill,
  output logic [OFF_W-1:0] word_off,
  output logic             wb_tag_sel,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             stall,
  output logic             done,
  output logic             cache_hit,
  output logic             err
);

  localparam int WORDS    = 1 << OFF_W;
  localparam int NUM_SETS = 1 << IDX_W;
  localparam int CW       = OFF_W + 1;

  localparam logic [CW-1:0] WORDS_C   = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C    = CW'(WORDS - 1);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_REPLAY,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic              victim;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;
  logic [CW-1:0]     out_cnt;
  logic [NUM_SETS-1:0] lru;

  logic req;
  logic hit_w0;
  logic hit_w1;
  logic hit_any;
  logic hit_way;
  logic miss_victim;
  logic victim_wb;
  logic err_in;
  logic ret;
  logic rd_issue;
  logic rd_accept;

  assign req     = rd | wr;
  assign hit_w0  = hit0 & valid0;
  assign hit_w1  = hit1 & valid1;
  assign hit_any = hit_w0 | hit_w1;
  // Way 0 wins if both ways claim a hit (should not happen with unique tags).
  assign hit_way = ~hit_w0;

  // Prefer an empty way; only fall back to LRU when both ways hold data.
  assign miss_victim = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[index]);
  assign victim_wb   = miss_victim ? (valid1 & dirty1) : (valid0 & dirty0);

  assign err_in = mem_err | cache_err;

  // Stray read data with nothing outstanding is dropped.
  assign ret = mem_rvalid && (out_cnt != '0);

  // A returning word owns word_off, so no new read is issued that cycle.
  assign rd_issue  = (state == S_FILL) && !ret && !err_in &&
                     (issue_cnt < WORDS_C) && (out_cnt < MAX_OUT_C);
  assign rd_accept = rd_issue && !mem_stall;

  // Output decode: array/memory controls follow the current state and inputs.
  always_comb begin
    comp        = 1'b0;
    way         = 1'b0;
    cache_en    = 1'b0;
    cache_write = 1'b0;
    fill        = 1'b0;
    word_off    = '0;
    wb_tag_sel  = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;
    unique case (state)
      S_IDLE: begin
        cache_en = 1'b1;
        if (req) begin
          comp = 1'b1;
          if (hit_any) begin
            way         = hit_way;
            cache_write = wr;
            done        = 1'b1;
            cache_hit   = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
      end
      S_WB: begin
        stall      = 1'b1;
        cache_en   = 1'b1;
        way        = victim;
        wb_tag_sel = 1'b1;
        mem_wr     = !err_in;
        word_off   = issue_cnt[OFF_W-1:0];
      end
      S_FILL: begin
        stall = 1'b1;
        way   = victim;
        if (ret && !err_in) begin
          cache_en    = 1'b1;
          cache_write = 1'b1;
          fill        = 1'b1;
          word_off    = recv_cnt[OFF_W-1:0];
        end else if (rd_issue) begin
          mem_rd   = 1'b1;
          word_off = issue_cnt[OFF_W-1:0];
        end
      end
      S_REPLAY: begin
        stall       = 1'b1;
        cache_en    = 1'b1;
        comp        = 1'b1;
        way         = victim;
        cache_write = wr & !err_in;
      end
      S_DONE: begin
        stall = 1'b1;
        done  = 1'b1;
      end
      S_ERR: begin
        stall = 1'b1;
        done  = 1'b1;
        err   = 1'b1;
      end
      default: begin
        stall = 1'b1;
      end
    endcase
  end

  // State, victim, burst counters and LRU bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      victim    <= 1'b0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      out_cnt   <= '0;
      lru       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            if (hit_any) begin
              lru[index] <= ~hit_way;
            end else begin
              victim <= miss_victim;
              state  <= victim_wb ? S_WB : S_FILL;
            end
          end
        end
        S_WB: begin
          if (err_in) begin
            state <= S_ERR;
          end else if (!mem_stall) begin
            if (issue_cnt == LAST_C) begin
              issue_cnt <= '0;
              state     <= S_FILL;
            end else begin
              issue_cnt <= issue_cnt + ONE_C;
            end
          end
        end
        S_FILL: begin
          if (err_in) begin
            state <= S_ERR;
          end else begin
            if (rd_accept) begin
              issue_cnt <= issue_cnt + ONE_C;
              out_cnt   <= out_cnt + ONE_C;
            end else if (ret) begin
              out_cnt <= out_cnt - ONE_C;
            end
            if (ret) begin
              recv_cnt <= recv_cnt + ONE_C;
              if (recv_cnt == LAST_C) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
                out_cnt   <= '0;
                state     <= S_REPLAY;
              end
            end
          end
        end
        S_REPLAY: begin
          if (err_in) begin
            state <= S_ERR;
          end else begin
            lru[index] <= ~victim;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_ERR: begin
          issue_cnt <= '0;
          recv_cnt  <= '0;
          out_cnt   <= '0;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed testbench for cache_ctrl_2way (OFF_W=2, IDX_W=8, MAX_OUT=4).
// A small memory model returns read data two cycles after each accepted read.
module tb_cache_ctrl_2way;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd, wr;
  logic [7:0] index;
  logic       hit0, hit1, valid0, valid1, dirty0, dirty1;
  logic       mem_stall, mem_rvalid, mem_err, cache_err;
  logic       comp, way, cache_en, cache_write, fill;
  logic [1:0] word_off;
  logic       wb_tag_sel, mem_rd, mem_wr, stall, done, cache_hit, err;

  int checks = 0;
  int errors = 0;

  logic [1:0]  rv_sr;
  logic [11:0] outs;

  assign outs = {cache_en, comp, way, cache_write, fill, wb_tag_sel,
                 mem_rd, mem_wr, stall, done, cache_hit, err};
  assign mem_rvalid = rv_sr[1];

  always #5 clk = ~clk;

  // Pipelined memory: read data appears two cycles after acceptance.
  always @(posedge clk) begin
    if (rst) rv_sr <= 2'b00;
    else     rv_sr <= {rv_sr[0], mem_rd & ~mem_stall};
  end

  cache_ctrl_2way #(.OFF_W(2), .IDX_W(8), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .index(index),
    .hit0(hit0), .hit1(hit1), .valid0(valid0), .valid1(valid1),
    .dirty0(dirty0), .dirty1(dirty1), .mem_stall(mem_stall),
    .mem_rvalid(mem_rvalid), .mem_err(mem_err), .cache_err(cache_err),
    .comp(comp), .way(way), .cache_en(cache_en), .cache_write(cache_write),
    .fill(fill), .word_off(word_off), .wb_tag_sel(wb_tag_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .stall(stall), .done(done),
    .cache_hit(cache_hit), .err(err)
  );

  task automatic clear_inputs();
    rd = 0; wr = 0; index = 0;
    hit0 = 0; hit1 = 0; valid0 = 0; valid1 = 0; dirty0 = 0; dirty1 = 0;
    mem_stall = 0; mem_err = 0; cache_err = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    @(negedge clk); #1;
    checks++;
    if (outs !== 12'h800 || word_off !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs got outs=%h word_off=%0d want outs=800 word_off=0", outs, word_off);
    end
    rst = 0;
    idle(2);
  endtask

  task automatic test_hit();
    // Write hit in way 0 sets lru[5]=1, then read hit in way 1 sets lru[5]=0.
    @(negedge clk);
    clear_inputs(); wr = 1; index = 8'd5; hit0 = 1; valid0 = 1; #1;
    checks++;
    if (done !== 1 || cache_hit !== 1 || way !== 0 || cache_write !== 1 || stall !== 0 || comp !== 1) begin
      errors++;
      $display("FAIL hit_wr_way0 got done=%0b hit=%0b way=%0b cw=%0b stall=%0b comp=%0b want 1 1 0 1 0 1",
               done, cache_hit, way, cache_write, stall, comp);
    end
    @(negedge clk);
    clear_inputs(); rd = 1; index = 8'd5; hit1 = 1; valid1 = 1; #1;
    checks++;
    if (done !== 1 || cache_hit !== 1 || way !== 1 || cache_write !== 0 || stall !== 0 ||
        mem_rd !== 0 || mem_wr !== 0 || err !== 0) begin
      errors++;
      $display("FAIL hit_rd_way1 got done=%0b hit=%0b way=%0b cw=%0b stall=%0b mrd=%0b mwr=%0b want 1 1 1 0 0 0 0",
               done, cache_hit, way, cache_write, stall, mem_rd, mem_wr);
    end
    // Valid but no tag match is a miss, not a hit.
    @(negedge clk);
    clear_inputs(); idle(2);
  endtask

  task automatic test_fill();
    int nrd = 0, nfill = 0, rep_cyc = -1, done_cyc = -1;
    @(negedge clk);
    clear_inputs(); rd = 1; index = 8'd3; #1;
    checks++;
    if (stall !== 1 || done !== 0 || comp !== 1 || mem_rd !== 0) begin
      errors++;
      $display("FAIL fill_miss_cycle got stall=%0b done=%0b comp=%0b mrd=%0b want 1 0 1 0", stall, done, comp, mem_rd);
    end
    for (int cyc = 1; cyc < 40; cyc++) begin
      @(negedge clk); #1;
      if (mem_rd) begin
        checks++;
        if (word_off !== 2'(nrd) || mem_rvalid !== 0) begin
          errors++;
          $display("FAIL fill_rd_off got %0d rvalid=%0b want %0d rvalid=0", word_off, mem_rvalid, nrd);
        end
        nrd++;
      end
      if (cache_write && fill) begin
        checks++;
        if (way !== 0 || word_off !== 2'(nfill)) begin
          errors++;
          $display("FAIL fill_write got way=%0b off=%0d want way=0 off=%0d", way, word_off, nfill);
        end
        nfill++;
      end
      if (comp && !done) begin
        rep_cyc = cyc;
        checks++;
        if (cache_write !== 0 || way !== 0 || stall !== 1) begin
          errors++;
          $display("FAIL fill_replay got cw=%0b way=%0b stall=%0b want 0 0 1", cache_write, way, stall);
        end
      end
      if (done) begin
        done_cyc = cyc;
        checks++;
        if (cache_hit !== 0 || err !== 0 || stall !== 1) begin
          errors++;
          $display("FAIL fill_done got hit=%0b err=%0b stall=%0b want 0 0 1", cache_hit, err, stall);
        end
        break;
      end
    end
    checks++;
    if (nrd != 4 || nfill != 4 || done_cyc != 10 || rep_cyc != 9) begin
      errors++;
      $display("FAIL fill_counts got rd=%0d fill=%0d replay=%0d done=%0d want 4 4 9 10", nrd, nfill, rep_cyc, done_cyc);
    end
    @(negedge clk);
    clear_inputs(); #1;
    checks++;
    if (outs !== 12'h800) begin
      errors++;
      $display("FAIL fill_back_idle got outs=%h want 800", outs);
    end
    idle(3);
  endtask

  task automatic test_writeback();
    int wb_acc = 0, stall_left = 3, nstall = 0, nwr = 0, nrd = 0, nfill = 0;
    int rep_cyc = -1, done_cyc = -1;
    // Hit way 0 at index 7 makes lru[7]=1.
    @(negedge clk);
    clear_inputs(); rd = 1; index = 8'd7; hit0 = 1; valid0 = 1;
    @(negedge clk);
    clear_inputs(); wr = 1; index = 8'd7; valid0 = 1; valid1 = 1; dirty1 = 1; #1;
    checks++;
    if (stall !== 1 || mem_wr !== 0 || done !== 0) begin
      errors++;
      $display("FAIL wb_miss_cycle got stall=%0b mwr=%0b done=%0b want 1 0 0", stall, mem_wr, done);
    end
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      mem_stall = (wb_acc == 2 && stall_left > 0);
      if (mem_stall) stall_left--;
      #1;
      if (mem_wr) begin
        nwr++;
        checks++;
        if (word_off !== 2'(wb_acc) || way !== 1 || wb_tag_sel !== 1 || cache_write !== 0) begin
          errors++;
          $display("FAIL wb_word got off=%0d way=%0b tagsel=%0b cw=%0b want off=%0d way=1 tagsel=1 cw=0",
                   word_off, way, wb_tag_sel, cache_write, wb_acc);
        end
        if (mem_stall) nstall++;
        else wb_acc++;
      end
      if (mem_rd) begin
        checks++;
        if (word_off !== 2'(nrd) || wb_acc != 4) begin
          errors++;
          $display("FAIL wb_fill_rd got off=%0d wb_done=%0d want off=%0d wb_done=4", word_off, wb_acc, nrd);
        end
        nrd++;
      end
      if (cache_write && fill) begin
        checks++;
        if (way !== 1 || word_off !== 2'(nfill)) begin
          errors++;
          $display("FAIL wb_fill_write got way=%0b off=%0d want way=1 off=%0d", way, word_off, nfill);
        end
        nfill++;
      end
      if (comp && !done) begin
        rep_cyc = cyc;
        checks++;
        if (cache_write !== 1 || way !== 1 || fill !== 0) begin
          errors++;
          $display("FAIL wb_replay got cw=%0b way=%0b fill=%0b want 1 1 0", cache_write, way, fill);
        end
      end
      if (done) begin
        done_cyc = cyc;
        checks++;
        if (cache_hit !== 0 || err !== 0) begin
          errors++;
          $display("FAIL wb_done got hit=%0b err=%0b want 0 0", cache_hit, err);
        end
        break;
      end
    end
    checks++;
    if (wb_acc != 4 || nwr != 7 || nstall != 3 || nrd != 4 || nfill != 4 || rep_cyc != 16 || done_cyc != 17) begin
      errors++;
      $display("FAIL wb_counts got wb=%0d wr=%0d stl=%0d rd=%0d fill=%0d rep=%0d done=%0d want 4 7 3 4 4 16 17",
               wb_acc, nwr, nstall, nrd, nfill, rep_cyc, done_cyc);
    end
    idle(3);
  endtask

  task automatic test_err_fill();
    int nfill = 0;
    logic seen = 0;
    @(negedge clk);
    clear_inputs(); rd = 1; index = 8'd9;
    for (int cyc = 1; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      mem_err = (nfill == 1);
      #1;
      if (mem_err) begin
        seen = 1;
        checks++;
        if (cache_write !== 0 || mem_rd !== 0 || done !== 0) begin
          errors++;
          $display("FAIL err_pulse_cycle got cw=%0b mrd=%0b done=%0b want 0 0 0", cache_write, mem_rd, done);
        end
      end else if (cache_write && fill) begin
        nfill++;
      end
    end
    @(negedge clk);
    mem_err = 0; #1;
    checks++;
    if (!seen || done !== 1 || err !== 1 || cache_hit !== 0 || stall !== 1 || cache_write !== 0) begin
      errors++;
      $display("FAIL err_done got seen=%0b done=%0b err=%0b hit=%0b stall=%0b cw=%0b want 1 1 1 0 1 0",
               seen, done, err, cache_hit, stall, cache_write);
    end
    @(negedge clk);
    clear_inputs(); #1;
    checks++;
    if (outs !== 12'h800) begin
      errors++;
      $display("FAIL err_back_idle got outs=%h want 800", outs);
    end
    idle(4);
  endtask

  // Each probe misses with both ways valid+dirty so the victim is lru[index];
  // the first write-back cycle shows it on way, then cache_err aborts.
  task automatic test_lru();
    logic [7:0] idx [4];
    logic       exp [4];
    idx[0] = 8'd5; exp[0] = 1'b0;
    idx[1] = 8'd3; exp[1] = 1'b1;
    idx[2] = 8'd7; exp[2] = 1'b0;
    idx[3] = 8'd9; exp[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      clear_inputs(); rd = 1; index = idx[k];
      valid0 = 1; valid1 = 1; dirty0 = 1; dirty1 = 1; mem_stall = 1;
      @(negedge clk); #1;
      checks++;
      if (mem_wr !== 1 || wb_tag_sel !== 1 || way !== exp[k]) begin
        errors++;
        $display("FAIL lru_victim idx=%0d got mwr=%0b way=%0b want mwr=1 way=%0b", idx[k], mem_wr, way, exp[k]);
      end
      @(negedge clk);
      cache_err = 1;
      @(negedge clk);
      cache_err = 0; #1;
      checks++;
      if (done !== 1 || err !== 1) begin
        errors++;
        $display("FAIL lru_probe_abort idx=%0d got done=%0b err=%0b want 1 1", idx[k], done, err);
      end
      idle(2);
    end
  endtask

  task automatic test_reset_mid_burst();
    // lru[3]=1 so the victim is way 1 before reset.
    @(negedge clk);
    clear_inputs(); rd = 1; index = 8'd3;
    valid0 = 1; valid1 = 1; dirty0 = 1; dirty1 = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 1; #1;
    checks++;
    if (mem_wr !== 1 || word_off !== 2'd1 || way !== 1) begin
      errors++;
      $display("FAIL rst_mid_wb_pre got mwr=%0b off=%0d way=%0b want 1 1 1", mem_wr, word_off, way);
    end
    @(negedge clk);
    rst = 0; rd = 0; #1;
    checks++;
    if (outs !== 12'h800 || word_off !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid_wb_idle got outs=%h off=%0d want 800 0", outs, word_off);
    end
    // LRU cleared: same probe now picks way 0 and starts at word 0.
    @(negedge clk);
    rd = 1; mem_stall = 1;
    @(negedge clk); #1;
    checks++;
    if (mem_wr !== 1 || way !== 0 || word_off !== 2'd0) begin
      errors++;
      $display("FAIL rst_lru_cleared got mwr=%0b way=%0b off=%0d want 1 0 0", mem_wr, way, word_off);
    end
    @(negedge clk);
    cache_err = 1;
    @(negedge clk);
    cache_err = 0;
    idle(2);
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    test_reset();
    test_hit();
    test_fill();
    test_writeback();
    test_err_fill();
    test_lru();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
